// File: rtl/pwm_multi_ch.sv
// Multi-channel PWM with a shared prescaled period counter and double-buffered duty values.
// Optional center-aligned (triangle) counting is enabled by defining PWM_CENTER_EN.
module pwm_multi_ch #(
   parameter int WIDTH      = 8,
   parameter int CHANNELS   = 4,
   parameter int PRESCALE_W = 8
) (
   input  logic                            clk,
   input  logic                            reset,
   input  logic                            en,
   input  logic [PRESCALE_W-1:0]           prescale,
   input  logic [CHANNELS*(WIDTH+1)-1:0]   duty,
   input  logic                            load,
`ifdef PWM_CENTER_EN
   input  logic                            center,
`endif
   output logic                            busy,
   output logic                            period_start,
   output logic [CHANNELS-1:0]             pwm
);

   localparam logic [WIDTH-1:0] MAX = {WIDTH{1'b1}};

   // Handshake: load is accepted only while busy=0; busy stays high until the
   // staged duty set is committed at a period boundary (or at once when disabled).
   logic [PRESCALE_W-1:0]          pre_cnt;
   logic [WIDTH-1:0]               cnt;
   logic [WIDTH-1:0]               cnt_next;
   logic [CHANNELS*(WIDTH+1)-1:0]  staging;
   logic [CHANNELS*(WIDTH+1)-1:0]  duty_act;
   logic [CHANNELS-1:0]            pwm_next;
   logic                           tick;
   logic                           boundary;
`ifdef PWM_CENTER_EN
   logic                           center_act;
   logic                           dir_down;
   logic                           dir_next;
`endif

   always_comb begin
      tick     = en && (pre_cnt >= prescale);
      cnt_next = cnt + 1'b1;
      boundary = tick && (cnt == MAX);
`ifdef PWM_CENTER_EN
      dir_next = dir_down;
      if (center_act) begin
         // Triangle: up to MAX, back down; the period ends on the 1 -> 0 step.
         boundary = 1'b0;
         if (dir_down) begin
            cnt_next = cnt - 1'b1;
            if (cnt == WIDTH'(1)) begin
               dir_next = 1'b0;
               boundary = tick;
            end
         end else if (cnt == MAX) begin
            cnt_next = cnt - 1'b1;
            dir_next = 1'b1;
         end
      end
`endif
      for (int i = 0; i < CHANNELS; i++) begin
         pwm_next[i] = en && ({1'b0, cnt} < duty_act[i*(WIDTH+1) +: WIDTH+1]);
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         pre_cnt      <= '0;
         cnt          <= '0;
         staging      <= '0;
         duty_act     <= '0;
         busy         <= 1'b0;
         period_start <= 1'b0;
         pwm          <= '0;
`ifdef PWM_CENTER_EN
         center_act   <= 1'b0;
         dir_down     <= 1'b0;
`endif
      end else begin
         if (!en) begin
            pre_cnt <= '0;
            cnt     <= '0;
         end else if (tick) begin
            pre_cnt <= '0;
            cnt     <= cnt_next;
         end else begin
            pre_cnt <= pre_cnt + 1'b1;
         end
         period_start <= boundary;
         pwm          <= pwm_next;
         if (busy) begin
            if (!en || boundary) begin
               duty_act <= staging;
               busy     <= 1'b0;
            end
         end else if (load) begin
            staging <= duty;
            busy    <= 1'b1;
         end
`ifdef PWM_CENTER_EN
         if (!en) begin
            center_act <= center;
            dir_down   <= 1'b0;
         end else if (tick) begin
            dir_down <= dir_next;
            if (boundary) center_act <= center;
         end
`endif
      end
   end

endmodule

// File: tb/tb_pwm_multi_ch.sv
// Randomized and directed bench for pwm_multi_ch (WIDTH=4, CHANNELS=2) against a
// tick-count reference model.
module tb_pwm_multi_ch;

   localparam int W  = 4;
   localparam int CH = 2;
   localparam int PERIOD = 1 << W;

   logic                 clk = 1'b0;
   logic                 reset = 1'b1;
   logic                 en = 1'b0;
   logic [7:0]           prescale = '0;
   logic [CH*(W+1)-1:0]  duty = '0;
   logic                 load = 1'b0;
`ifdef PWM_CENTER_EN
   logic                 center = 1'b0;
`endif
   logic                 busy;
   logic                 period_start;
   logic [CH-1:0]        pwm;

   pwm_multi_ch #(.WIDTH(W), .CHANNELS(CH), .PRESCALE_W(8)) dut (
      .clk(clk), .reset(reset), .en(en), .prescale(prescale), .duty(duty), .load(load),
`ifdef PWM_CENTER_EN
      .center(center),
`endif
      .busy(busy), .period_start(period_start), .pwm(pwm)
   );

   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;
   int hi0, hi1, ps_cnt;

   // Reference model: counter value is derived from the number of ticks since enable.
   int m_pre, m_ticks, m_busy;
   int m_act[CH];
   int m_stage[CH];
   logic [CH-1:0] exp_pwm;
   logic          exp_ps;
   logic          exp_busy;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic model_step();
      int  c;
      logic t, bnd;
      if (reset) begin
         m_pre = 0; m_ticks = 0; m_busy = 0;
         for (int i = 0; i < CH; i++) begin m_act[i] = 0; m_stage[i] = 0; end
         exp_pwm = '0; exp_ps = 1'b0;
      end else begin
         c   = m_ticks % PERIOD;
         t   = en && (m_pre >= int'(prescale));
         bnd = t && (c == PERIOD - 1);
         for (int i = 0; i < CH; i++) exp_pwm[i] = en && (c < m_act[i]);
         exp_ps = bnd;
         if (!en) begin m_pre = 0; m_ticks = 0; end
         else if (t) begin m_pre = 0; m_ticks++; end
         else m_pre++;
         if (m_busy != 0) begin
            if (!en || bnd) begin
               for (int i = 0; i < CH; i++) m_act[i] = m_stage[i];
               m_busy = 0;
            end
         end else if (load) begin
            for (int i = 0; i < CH; i++) m_stage[i] = int'(duty[i*(W+1) +: W+1]);
            m_busy = 1;
         end
      end
      exp_busy = (m_busy != 0);
   endtask

   task automatic step();
      model_step();
      @(posedge clk);
      #1;
      check("pwm", 32'(pwm), 32'(exp_pwm));
      check("busy", 32'(busy), 32'(exp_busy));
      check("period_start", 32'(period_start), 32'(exp_ps));
      hi0    += int'(pwm[0]);
      hi1    += int'(pwm[1]);
      ps_cnt += int'(period_start);
      load = 1'b0;
   endtask

   task automatic steps(input int n);
      for (int i = 0; i < n; i++) step();
   endtask

   task automatic wait_busy_clear();
      int k = 0;
      while (busy && k < 400) begin step(); k++; end
      check("busy_timeout", 32'(busy), 32'd0);
   endtask

   task automatic clear_counts();
      hi0 = 0; hi1 = 0; ps_cnt = 0;
   endtask

   task automatic set_duty(input int d0, input int d1);
      logic [W:0] a, b;
      a = (W+1)'(d0);
      b = (W+1)'(d1);
      duty = {b, a};
   endtask

   initial begin
      // Reset with en high for two clocks.
      reset = 1'b1; en = 1'b1;
      steps(2);
      check("rst_pwm", 32'(pwm), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      reset = 1'b0;

      // prescale=0: ch0=4/16, ch1 full.
      prescale = 8'd0; set_duty(4, 16); load = 1'b1;
      step();
      wait_busy_clear();
      check("ps_at_commit", 32'(period_start), 32'd1);
      clear_counts(); steps(32);
      check("s2_hi0", hi0, 8);
      check("s2_hi1", hi1, 32);
      check("s2_ps", ps_cnt, 2);

      // prescale=2: 48-clock period, 12 high clocks on ch0.
      prescale = 8'd2;
      steps(60);
      clear_counts(); steps(96);
      check("s3_ps", ps_cnt, 2);
      check("s3_hi0", hi0, 24);
      check("s3_hi1", hi1, 96);

      // duty 0 and saturating 31.
      set_duty(0, 31); load = 1'b1;
      step();
      wait_busy_clear();
      clear_counts(); steps(96);
      check("s4_hi0", hi0, 0);
      check("s4_hi1", hi1, 96);

      // Second load while busy is ignored.
      prescale = 8'd0; set_duty(4, 0); load = 1'b1;
      step();
      wait_busy_clear();
      steps(5);
      set_duty(8, 0); load = 1'b1;
      step();
      check("s5_busy_set", 32'(busy), 32'd1);
      steps(2);
      set_duty(2, 0); load = 1'b1;
      step();
      wait_busy_clear();
      clear_counts(); steps(32);
      check("s5_hi0", hi0, 16);

      // Reset while ch0 is high mid-period.
      set_duty(4, 3); load = 1'b1;
      step();
      wait_busy_clear();
      steps(3);
      check("s6_pwm_high", 32'(pwm[0]), 32'd1);
      reset = 1'b1;
      step();
      check("s6_pwm_rst", 32'(pwm), 32'd0);
      reset = 1'b0;
      clear_counts(); steps(40);
      check("s6_hi", hi0 + hi1, 0);

      // Random traffic: enables, prescale changes, loads and rare resets.
      for (int i = 0; i < 2000; i++) begin
         reset = ($urandom_range(0, 299) == 0);
         en    = ($urandom_range(0, 24) != 0);
         if ($urandom_range(0, 59) == 0) prescale = 8'($urandom_range(0, 3));
         load  = ($urandom_range(0, 9) == 0);
         duty  = (CH*(W+1))'($urandom);
         step();
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
